// File: rtl/demux12_4.sv
// 1-to-2 demultiplexer with an independent 1-entry output register per channel.
// Optional per-channel transfer counters are compiled in when DEMUX12_4_CNT_EN is defined.
module demux12_4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in,
  input  logic       in_valid,
  input  logic       sel,
  output logic       in_ready,
  output logic [3:0] out1,
  output logic       out1_valid,
  input  logic       out1_ready,
  output logic [3:0] out2,
  output logic       out2_valid,
  input  logic       out2_ready,
  output logic [7:0] cnt1,
  output logic [7:0] cnt2
);

  // Handshake: a word moves on a rising clk edge exactly when valid && ready are
  // both high; a producer holds data/valid stable until that edge, and ready for
  // the input side depends only on the channel named by the current sel.

  logic [3:0] data1_q, data1_d;
  logic [3:0] data2_q, data2_d;
  logic       vld1_q, vld1_d;
  logic       vld2_q, vld2_d;

  logic       ready1;
  logic       ready2;
  logic       xfer_in;
  logic       load1;
  logic       load2;
  logic       drain1;
  logic       drain2;

  // A channel can take a word if it is empty or is emptying on this same edge.
  assign ready1   = !vld1_q || out1_ready;
  assign ready2   = !vld2_q || out2_ready;
  assign in_ready = sel ? ready2 : ready1;

  assign xfer_in  = in_valid && in_ready;
  assign load1    = xfer_in && !sel;
  assign load2    = xfer_in && sel;
  assign drain1   = vld1_q && out1_ready;
  assign drain2   = vld2_q && out2_ready;

  always_comb begin
    data1_d = data1_q;
    vld1_d  = vld1_q;
    if (load1) begin
      data1_d = in;
      vld1_d  = 1'b1;
    end else if (drain1) begin
      vld1_d  = 1'b0;
    end
  end

  always_comb begin
    data2_d = data2_q;
    vld2_d  = vld2_q;
    if (load2) begin
      data2_d = in;
      vld2_d  = 1'b1;
    end else if (drain2) begin
      vld2_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data1_q <= 4'b0000;
      data2_q <= 4'b0000;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
    end else begin
      data1_q <= data1_d;
      data2_q <= data2_d;
      vld1_q  <= vld1_d;
      vld2_q  <= vld2_d;
    end
  end

  assign out1       = data1_q;
  assign out1_valid = vld1_q;
  assign out2       = data2_q;
  assign out2_valid = vld2_q;

`ifdef DEMUX12_4_CNT_EN
  logic [7:0] cnt1_q, cnt1_d;
  logic [7:0] cnt2_q, cnt2_d;

  // Counters wrap naturally at 8 bits.
  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if (drain1) cnt1_d = cnt1_q + 8'd1;
    if (drain2) cnt2_d = cnt2_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt1_q <= 8'h00;
      cnt2_q <= 8'h00;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

  assign cnt1 = cnt1_q;
  assign cnt2 = cnt2_q;
`else
  assign cnt1 = 8'h00;
  assign cnt2 = 8'h00;
`endif

endmodule

// File: doc/demux12_4.md
DEMUX12_4 -- requirements
Module: demux12_4

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: in  input  4  upstream data word.
REQ-004 SHALL have port: in_valid  input  1  upstream word present.
REQ-005 SHALL have port: sel  input  1  destination: 0 -> out1, 1 -> out2; qualified by in_valid.
REQ-006 SHALL have port: in_ready  output  1  block accepts word this cycle.
REQ-007 SHALL have port: out1  output  4  channel-1 data.
REQ-008 SHALL have port: out1_valid  output  1  channel-1 word present.
REQ-009 SHALL have port: out1_ready  input  1  channel-1 consumer accepts.
REQ-010 SHALL have port: out2  output  4  channel-2 data.
REQ-011 SHALL have port: out2_valid  output  1  channel-2 word present.
REQ-012 SHALL have port: out2_ready  input  1  channel-2 consumer accepts.
REQ-013 SHALL have port: cnt1  output  8  channel-1 transfer count (REQ-031 only).
REQ-014 SHALL have port: cnt2  output  8  channel-2 transfer count (REQ-031 only).

Function
REQ-015 SHALL hold one independent 1-entry register per channel (data + valid flag); outN/outN_valid driven directly from the register.
REQ-016 SHALL define input transfer as in_valid && in_ready, and output transfer N as outN_valid && outN_ready, both on the rising clk edge.
REQ-017 SHALL drive in_ready combinationally: !outS_valid || outS_ready, where S is the channel chosen by current sel.
REQ-018 SHALL, on input transfer, load in into register S and set outS_valid on the next edge (latency 1 cycle).
REQ-019 SHALL sample sel only on input-transfer cycles; a sel change while in_valid is low has no effect.
REQ-020 SHALL, on output transfer N with no input transfer to N, clear outN_valid next edge.
REQ-021 SHALL, when output transfer N and input transfer to N coincide, load the new word and keep outN_valid = 1 (full throughput, no bubble).
REQ-022 SHALL hold outN and outN_valid stable while outN_valid && !outN_ready (no overwrite, no drop).
REQ-023 SHALL let a stalled channel block only words selected to it; words for the other channel proceed.
REQ-024 SHALL let both channels drain on the same edge, independently of input activity.
REQ-025 SHALL never duplicate, reorder within a channel, or lose a word.

Reset
REQ-026 SHALL, while rst = 1, force out1 = out2 = 4'b0000, out1_valid = out2_valid = 0, cnt1 = cnt2 = 8'h00, asynchronously.
REQ-027 SHALL drive in_ready = 1 during reset, with no transfer committed while rst = 1.
REQ-028 SHALL, on reset asserted mid-operation, discard all held words; the first word accepted after release is output first.
REQ-029 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Configuration
REQ-030 SHALL compile transfer counters only when macro DEMUX12_4_CNT_EN is defined.
REQ-031 SHALL, with DEMUX12_4_CNT_EN defined, increment cntN by 1 on each output transfer N, wrapping 8'hFF -> 8'h00.
REQ-032 SHALL, without DEMUX12_4_CNT_EN, keep cnt1/cnt2 ports present and tie them to 8'h00, with no counter flops.

Verification
REQ-033 SHALL cover routing: in=1010,sel=0,valid 1 cycle, both readies 1 -> out1=1010,out1_valid=1 next cycle; out2_valid stays 0; then in=0101,sel=1 -> out2=0101.
REQ-034 SHALL cover backpressure: out1_ready=0, send 1111 to ch1 -> out1 holds 1111; next ch1 word sees in_ready=0 until out1_ready=1; a ch2 word (0000) is accepted meanwhile.
REQ-035 SHALL cover throughput: 4 back-to-back ch2 words 0001,0010,0011,0100 with out2_ready=1 -> out2_valid stays 1 for 4 consecutive cycles, data in order.
REQ-036 SHALL cover reset: assert rst mid-stall with out1_valid=1 -> out1_valid=0, out1=0000 immediately without a clk edge; after release, first word is accepted with 1-cycle latency.
REQ-037 SHALL cover counters (macro defined): 257 ch1 transfers -> cnt1=8'h01, cnt2=8'h00; macro undefined -> both 8'h00 throughout.
